// File: rtl/imm_pkg.sv
// Shared opcode constants and immediate-format encoding for the immediate generator.
package imm_pkg;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_B      = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_J      = 7'b1101111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtNone = 3'd7
    } fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);

    logic [31:0] w_imm32;
    fmt_e        w_fmt;
    logic        w_illegal;

    // Every format fits in 32 bits with instr[31] as sign; widen to XLEN afterwards.
    always_comb begin
        w_imm32   = '0;
        w_fmt     = FmtNone;
        w_illegal = 1'b1;
        case (i_instr[6:0])
            OP_LW, OP_I, OP_JALR: begin
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                w_fmt     = FmtI;
                w_illegal = 1'b0;
            end
            OP_SW: begin
                w_imm32   = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_fmt     = FmtS;
                w_illegal = 1'b0;
            end
            OP_B: begin
                w_imm32   = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                             i_instr[11:8], 1'b0};
                w_fmt     = FmtB;
                w_illegal = 1'b0;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32   = {i_instr[31:12], 12'b0};
                w_fmt     = FmtU;
                w_illegal = 1'b0;
            end
            OP_J: begin
                w_imm32   = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                             i_instr[30:21], 1'b0};
                w_fmt     = FmtJ;
                w_illegal = 1'b0;
            end
            OP_R: begin
                w_fmt     = FmtR;
                w_illegal = 1'b0;
            end
            OP_IMM_32: begin
                if (XLEN == 64) begin
                    w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                    w_fmt     = FmtI;
                    w_illegal = 1'b0;
                end
            end
            OP_32: begin
                if (XLEN == 64) begin
                    w_fmt     = FmtR;
                    w_illegal = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign o_imm     = XLEN'($signed(w_imm32));
    assign o_fmt     = w_fmt;
    assign o_illegal = w_illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready handshake and one-entry skid buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [31:0]      i_in_instr,
    input  logic [TAG_W-1:0] i_in_tag,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [XLEN-1:0]  o_out_imm,
    output logic [2:0]       o_out_fmt,
    output logic             o_out_illegal,
    output logic [TAG_W-1:0] o_out_tag
);

    logic [XLEN-1:0]  w_dec_imm;
    logic [2:0]       w_dec_fmt;
    logic             w_dec_illegal;
    logic             w_accept;
    logic             w_main_free;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic             r_main_illegal;
    logic [TAG_W-1:0] r_main_tag;

    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_illegal;
    logic [TAG_W-1:0] r_skid_tag;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_instr   (i_in_instr),
        .o_imm     (w_dec_imm),
        .o_fmt     (w_dec_fmt),
        .o_illegal (w_dec_illegal)
    );

    assign w_accept    = i_in_valid && o_in_ready;
    assign w_main_free = !r_main_valid || i_out_ready;

    // Skid only fills while main is full, so a free main with a full skid means a drain.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_main_valid   <= 1'b0;
            r_main_imm     <= '0;
            r_main_fmt     <= '0;
            r_main_illegal <= 1'b0;
            r_main_tag     <= '0;
            r_skid_valid   <= 1'b0;
            r_skid_imm     <= '0;
            r_skid_fmt     <= '0;
            r_skid_illegal <= 1'b0;
            r_skid_tag     <= '0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                r_main_valid   <= 1'b1;
                r_main_imm     <= r_skid_imm;
                r_main_fmt     <= r_skid_fmt;
                r_main_illegal <= r_skid_illegal;
                r_main_tag     <= r_skid_tag;
                r_skid_valid   <= 1'b0;
            end else if (w_accept) begin
                r_main_valid   <= 1'b1;
                r_main_imm     <= w_dec_imm;
                r_main_fmt     <= w_dec_fmt;
                r_main_illegal <= w_dec_illegal;
                r_main_tag     <= i_in_tag;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_accept) begin
            r_skid_valid   <= 1'b1;
            r_skid_imm     <= w_dec_imm;
            r_skid_fmt     <= w_dec_fmt;
            r_skid_illegal <= w_dec_illegal;
            r_skid_tag     <= i_in_tag;
        end
    end

    assign o_in_ready    = !r_skid_valid;
    assign o_out_valid   = r_main_valid;
    assign o_out_imm     = r_main_imm;
    assign o_out_fmt     = r_main_fmt;
    assign o_out_illegal = r_main_illegal;
    assign o_out_tag     = r_main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances, vector table plus stall/flush/reset.
module tb_imm_gen_pipe;

    typedef struct {
        bit          is64;
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    logic        s32_in_valid, s32_in_ready, s32_out_valid, s32_out_ready, s32_ill;
    logic [31:0] s32_instr, s32_imm;
    logic [7:0]  s32_tag, s32_out_tag;
    logic [2:0]  s32_fmt;

    logic        s64_in_valid, s64_in_ready, s64_out_valid, s64_out_ready, s64_ill;
    logic [31:0] s64_instr;
    logic [63:0] s64_imm;
    logic [7:0]  s64_tag, s64_out_tag;
    logic [2:0]  s64_fmt;

    int n_err = 0;
    int n_chk = 0;
    logic [7:0] got32[$];
    vec_t vecs[$];

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .i_clk (clk), .i_rst_n (rst_n), .i_flush (flush),
        .i_in_valid (s32_in_valid), .o_in_ready (s32_in_ready),
        .i_in_instr (s32_instr), .i_in_tag (s32_tag),
        .o_out_valid (s32_out_valid), .i_out_ready (s32_out_ready),
        .o_out_imm (s32_imm), .o_out_fmt (s32_fmt),
        .o_out_illegal (s32_ill), .o_out_tag (s32_out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .i_clk (clk), .i_rst_n (rst_n), .i_flush (flush),
        .i_in_valid (s64_in_valid), .o_in_ready (s64_in_ready),
        .i_in_instr (s64_instr), .i_in_tag (s64_tag),
        .o_out_valid (s64_out_valid), .i_out_ready (s64_out_ready),
        .o_out_imm (s64_imm), .o_out_fmt (s64_fmt),
        .o_out_illegal (s64_ill), .o_out_tag (s64_out_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s32_out_valid && s32_out_ready) got32.push_back(s32_out_tag);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [23:0] order;

        vecs.push_back('{1'b0, 32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0});
        vecs.push_back('{1'b0, 32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0});
        vecs.push_back('{1'b0, 32'h123450B7, 64'h12345000, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 32'hFE000EE3, 64'hFFFFFFFC, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h00000463, 64'h00000008, 3'd3, 1'b0});
        vecs.push_back('{1'b0, 32'h00001017, 64'h00001000, 3'd4, 1'b0});
        vecs.push_back('{1'b0, 32'h00412083, 64'h00000004, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 32'h000080E7, 64'h00000000, 3'd1, 1'b0});
        vecs.push_back('{1'b0, 32'h001000EF, 64'h00000800, 3'd5, 1'b0});
        vecs.push_back('{1'b0, 32'h002081B3, 64'h00000000, 3'd0, 1'b0});
        vecs.push_back('{1'b0, 32'h0000007F, 64'h00000000, 3'd7, 1'b1});
        vecs.push_back('{1'b0, 32'h0000001B, 64'h00000000, 3'd7, 1'b1});
        vecs.push_back('{1'b0, 32'h0000003B, 64'h00000000, 3'd7, 1'b1});
        vecs.push_back('{1'b1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0});
        vecs.push_back('{1'b1, 32'h123450B7, 64'h0000000012345000, 3'd4, 1'b0});
        vecs.push_back('{1'b1, 32'hFFF0809B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0});
        vecs.push_back('{1'b1, 32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0});
        vecs.push_back('{1'b1, 32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1});

        // Reset with live inputs: they must be ignored.
        rst_n = 1'b0; flush = 1'b0;
        s32_in_valid = 1'b1; s32_instr = 32'hFFF00093; s32_tag = 8'hAA; s32_out_ready = 1'b1;
        s64_in_valid = 1'b1; s64_instr = 32'hFFF00093; s64_tag = 8'hAA; s64_out_ready = 1'b1;
        tick(); tick();
        chk("rst32_valid", s32_out_valid, 0);
        chk("rst32_imm", s32_imm, 0);
        chk("rst32_fmt", s32_fmt, 0);
        chk("rst32_ill", s32_ill, 0);
        chk("rst32_tag", s32_out_tag, 0);
        chk("rst32_ready", s32_in_ready, 1);
        chk("rst64_valid", s64_out_valid, 0);
        chk("rst64_imm", s64_imm, 0);
        chk("rst64_ready", s64_in_ready, 1);
        rst_n = 1'b1; s32_in_valid = 1'b0; s64_in_valid = 1'b0;
        tick();
        chk("post_rst_valid", s32_out_valid, 0);

        // Back-to-back vectors, one per cycle.
        for (int i = 0; i < vecs.size(); i++) begin
            s32_in_valid = !vecs[i].is64; s32_instr = vecs[i].instr; s32_tag = 8'(i + 16);
            s64_in_valid = vecs[i].is64;  s64_instr = vecs[i].instr; s64_tag = 8'(i + 16);
            tick();
            if (vecs[i].is64) begin
                chk($sformatf("v%0d_valid", i), s64_out_valid, 1);
                chk($sformatf("v%0d_imm", i), s64_imm, vecs[i].imm);
                chk($sformatf("v%0d_fmt", i), s64_fmt, vecs[i].fmt);
                chk($sformatf("v%0d_ill", i), s64_ill, vecs[i].ill);
                chk($sformatf("v%0d_tag", i), s64_out_tag, 64'(i + 16));
            end else begin
                chk($sformatf("v%0d_valid", i), s32_out_valid, 1);
                chk($sformatf("v%0d_imm", i), s32_imm, vecs[i].imm);
                chk($sformatf("v%0d_fmt", i), s32_fmt, vecs[i].fmt);
                chk($sformatf("v%0d_ill", i), s32_ill, vecs[i].ill);
                chk($sformatf("v%0d_tag", i), s32_out_tag, 64'(i + 16));
            end
        end
        s32_in_valid = 1'b0; s64_in_valid = 1'b0;
        tick();
        chk("drain32_valid", s32_out_valid, 0);
        chk("drain64_valid", s64_out_valid, 0);

        // Stall: tags 1,2,3 offered while downstream is blocked.
        got32.delete();
        s32_out_ready = 1'b0;
        s32_in_valid = 1'b1; s32_instr = 32'hFFF00093; s32_tag = 8'd1;
        tick();
        chk("stall_v1", s32_out_valid, 1);
        chk("stall_t1", s32_out_tag, 1);
        chk("stall_rdy1", s32_in_ready, 1);
        s32_instr = 32'h123450B7; s32_tag = 8'd2;
        tick();
        chk("stall_rdy2", s32_in_ready, 0);
        chk("stall_t2", s32_out_tag, 1);
        chk("stall_imm2", s32_imm, 32'hFFFFFFFF);
        s32_instr = 32'hFE112E23; s32_tag = 8'd3;
        tick();
        chk("stall_rdy3", s32_in_ready, 0);
        chk("stall_t3", s32_out_tag, 1);
        chk("stall_imm3", s32_imm, 32'hFFFFFFFF);
        chk("stall_fmt3", s32_fmt, 1);
        s32_out_ready = 1'b1;
        tick();
        chk("rel_t2", s32_out_tag, 2);
        chk("rel_imm2", s32_imm, 32'h12345000);
        chk("rel_rdy", s32_in_ready, 1);
        tick();
        chk("rel_t3", s32_out_tag, 3);
        chk("rel_imm3", s32_imm, 32'hFFFFFFFC);
        s32_in_valid = 1'b0;
        tick();
        chk("rel_empty", s32_out_valid, 0);
        chk("stall_count", got32.size(), 3);
        order = '0;
        for (int i = 0; i < got32.size() && i < 3; i++) order[23 - 8*i -: 8] = got32[i];
        chk("stall_order", order, 24'h010203);

        // Flush with main and skid full and a pending input.
        got32.delete();
        s32_out_ready = 1'b0;
        s32_in_valid = 1'b1; s32_instr = 32'hFFF00093; s32_tag = 8'd7;
        tick();
        s32_tag = 8'd8;
        tick();
        chk("fl_full", s32_in_ready, 0);
        s32_tag = 8'd9; flush = 1'b1;
        tick();
        chk("fl_valid", s32_out_valid, 0);
        chk("fl_ready", s32_in_ready, 1);
        flush = 1'b0; s32_in_valid = 1'b0; s32_out_ready = 1'b1;
        tick(); tick(); tick();
        chk("fl_none", got32.size(), 0);

        // Flush beats a same-cycle accept.
        s32_out_ready = 1'b0;
        s32_in_valid = 1'b1; s32_tag = 8'd10;
        tick();
        s32_tag = 8'd11; flush = 1'b1;
        tick();
        chk("fla_valid", s32_out_valid, 0);
        chk("fla_ready", s32_in_ready, 1);
        flush = 1'b0; s32_in_valid = 1'b0; s32_out_ready = 1'b1;
        tick(); tick();
        chk("fla_none", got32.size(), 0);

        // Reset in the middle of a stall on the 64-bit instance.
        s64_out_ready = 1'b0;
        s64_in_valid = 1'b1; s64_instr = 32'hFFF00093; s64_tag = 8'd5;
        tick();
        s64_instr = 32'h800000B7; s64_tag = 8'd6;
        tick();
        chk("r64_full", s64_in_ready, 0);
        s64_in_valid = 1'b0; rst_n = 1'b0;
        tick();
        chk("r64_valid", s64_out_valid, 0);
        chk("r64_imm", s64_imm, 0);
        chk("r64_fmt", s64_fmt, 0);
        chk("r64_ill", s64_ill, 0);
        chk("r64_tag", s64_out_tag, 0);
        chk("r64_ready", s64_in_ready, 1);
        rst_n = 1'b1; s64_out_ready = 1'b1;
        tick();
        chk("r64_gone", s64_out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
